// File: rtl/wbuf_pkg.sv
// Shared types and sizing for the eviction write buffer.
// Entry layout is {valid, tag, data}; the tag is the line address without its offset bits.
package wbuf_pkg;

    localparam int WB_DEPTH    = 4;
    localparam int WB_LINE_W   = 256;
    localparam int WB_ADDR_W   = 32;
    localparam int WB_OFFSET_W = 5;
    localparam int TAG_W       = WB_ADDR_W - WB_OFFSET_W;
    localparam int PTR_W       = $clog2(WB_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ_MEM,
        DRAIN,
        RESP
    } wbuf_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [WB_LINE_W-1:0] data;
    } wbuf_entry_t;

    // Pointers wrap for free because DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/wbuf_match.sv
// Tag compare across all buffered lines: purely combinational, zero latency.
// No backpressure; at most one valid entry can carry a given tag.
module wbuf_match
    import wbuf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic [DEPTH-1:0] ent_valid,
    input  logic [TAG_W-1:0] ent_tag [DEPTH],
    input  logic [TAG_W-1:0] tag,
    input  logic [PTR_W-1:0] head,
    output logic             hit,
    output logic [PTR_W-1:0] hit_idx,
    output logic             hit_is_head
);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_tag[i] == tag)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign hit_is_head = hit && (hit_idx == head);

endmodule

// File: rtl/eviction_write_buffer.sv
// Line write-back buffer: evictions retire into a FIFO in one cycle, drain to memory when the cache is idle.
// Latency: buffered write / read hit respond the cycle after acceptance; read miss one cycle after mem_resp.
// Backpressure: cache requests are held until cache_resp; a full buffer drains its head before accepting.
module eviction_write_buffer
    import wbuf_pkg::*;
#(
    parameter int DEPTH    = WB_DEPTH,
    parameter int LINE_W   = WB_LINE_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int OFFSET_W = WB_OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_read,
    input  logic              cache_write,
    input  logic [ADDR_W-1:0] cache_address,
    input  logic [LINE_W-1:0] cache_wdata,
    output logic [LINE_W-1:0] cache_rdata,
    output logic              cache_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    wbuf_state_e      state, state_nxt;
    wbuf_entry_t      entries [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [TAG_W-1:0] ent_tag [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic [TAG_W-1:0] req_tag;
    logic             hit, hit_is_head, head_busy;
    logic [PTR_W-1:0] hit_idx;
    logic             full, empty;
    logic             do_coalesce, do_alloc, do_hit_read, start_read, start_drain, read_done, pop;

    assign req_tag    = cache_address[ADDR_W-1:OFFSET_W];
    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign cache_resp = (state == RESP);
    // The head is untouchable only while its drain is on the bus.
    assign head_busy  = hit_is_head && mem_write;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = entries[i].valid;
            ent_tag[i]   = entries[i].tag;
        end
    end

    wbuf_match #(.DEPTH(DEPTH)) u_match (
        .ent_valid   (ent_valid),
        .ent_tag     (ent_tag),
        .tag         (req_tag),
        .head        (head),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .hit_is_head (hit_is_head)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        do_coalesce = 1'b0;
        do_alloc    = 1'b0;
        do_hit_read = 1'b0;
        start_read  = 1'b0;
        start_drain = 1'b0;
        read_done   = 1'b0;
        pop         = 1'b0;
        unique case (state)
            IDLE: begin
                if (cache_write) begin
                    if (hit && !head_busy) begin
                        do_coalesce = 1'b1;
                        state_nxt   = RESP;
                    end else if (!full) begin
                        do_alloc  = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        // Write stays pending and is retried once the head has popped.
                        start_drain = 1'b1;
                        state_nxt   = DRAIN;
                    end
                end else if (cache_read) begin
                    if (hit && !head_busy) begin
                        do_hit_read = 1'b1;
                        state_nxt   = RESP;
                    end else begin
                        start_read = 1'b1;
                        state_nxt  = READ_MEM;
                    end
                end else if (!empty) begin
                    start_drain = 1'b1;
                    state_nxt   = DRAIN;
                end
            end
            READ_MEM: if (mem_resp) begin
                read_done = 1'b1;
                state_nxt = RESP;
            end
            DRAIN: if (mem_resp) begin
                pop       = 1'b1;
                state_nxt = IDLE;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            cache_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
        end else begin
            if (do_coalesce) entries[hit_idx].data <= cache_wdata;
            if (do_alloc) begin
                entries[tail] <= '{valid: 1'b1, tag: req_tag, data: cache_wdata};
                tail          <= ptr_inc(tail);
                count         <= count + 1'b1;
            end
            if (do_hit_read) cache_rdata <= entries[hit_idx].data;
            if (start_read) begin
                mem_read    <= 1'b1;
                mem_address <= cache_address;
            end
            if (start_drain) begin
                mem_write   <= 1'b1;
                mem_address <= {entries[head].tag, OFFSET_W'(0)};
                mem_wdata   <= entries[head].data;
            end
            if (read_done) begin
                mem_read    <= 1'b0;
                cache_rdata <= mem_rdata;
            end
            if (pop) begin
                mem_write               <= 1'b0;
                entries[head].valid     <= 1'b0;
                head                    <= ptr_inc(head);
                count                   <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Bench for eviction_write_buffer: directed scenarios then random traffic against a line-level memory model.
// The model is a FIFO of distinct dirty tags plus a golden "latest value per line" map.
module tb_eviction_write_buffer;

    localparam int DEPTH    = 4;
    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int TW       = ADDR_W - OFFSET_W;
    localparam time T       = 10;

    typedef logic [TW-1:0]     tag_t;
    typedef logic [LINE_W-1:0] line_t;
    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        line_t             data;
    } ev_t;

    logic              clk, rst;
    logic              cache_read, cache_write, cache_resp;
    logic [ADDR_W-1:0] cache_address, mem_address;
    line_t             cache_wdata, cache_rdata, mem_wdata, mem_rdata;
    logic              mem_read, mem_write, mem_resp;

    eviction_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
        .clk(clk), .rst(rst),
        .cache_read(cache_read), .cache_write(cache_write), .cache_address(cache_address),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_resp(cache_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #(T/2) clk = ~clk;
    end

    int    total = 0, bad = 0;
    line_t backing [tag_t];
    line_t golden  [tag_t];
    tag_t  q_tag [$];
    line_t q_dat [$];
    ev_t   log_q [$];
    int    n_rd = 0, n_wr = 0;
    int    resp_delay = -1;
    bit    abort_ok = 1'b0;
    time   mresp_time = 0;
    logic [ADDR_W-1:0] cur_addr = '0;

    task automatic check(input string name, input line_t obs, input line_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic line_t init_line(input tag_t t);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ {5'd0, t};
        return {8{w}};
    endfunction

    function automatic line_t mem_val(input tag_t t);
        return backing.exists(t) ? backing[t] : init_line(t);
    endfunction

    function automatic line_t gold(input tag_t t);
        return golden.exists(t) ? golden[t] : mem_val(t);
    endfunction

    function automatic int find_q(input tag_t t);
        for (int i = 0; i < q_tag.size(); i++) if (q_tag[i] == t) return i;
        return -1;
    endfunction

    // Memory side: random or forced response delay, records every bus transaction.
    initial begin : mem_model
        int                pend;
        bit                kind_wr;
        logic [ADDR_W-1:0] a;
        line_t             d;
        pend      = -1;
        kind_wr   = 1'b0;
        a         = '0;
        d         = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            check("mem_rd_wr_exclusive", line_t'(mem_read && mem_write), '0);
            check("cache_rd_wr_exclusive", line_t'(cache_read && cache_write), '0);
            if (mem_resp) begin
                mem_resp = 1'b0;
                continue;
            end
            if (pend < 0 && !rst && (mem_read || mem_write)) begin
                kind_wr = mem_write;
                a       = mem_address;
                d       = mem_wdata;
                pend    = (resp_delay < 0) ? int'($urandom_range(0, 3)) : resp_delay;
                log_q.push_back('{kind_wr, a, d});
                if (kind_wr) begin
                    n_wr++;
                    if (q_tag.size() == 0) check("drain_unexpected", 1, 0);
                    else begin
                        check("drain_tag_order", line_t'(a[ADDR_W-1:OFFSET_W]), line_t'(q_tag[0]));
                        check("drain_data", d, q_dat[0]);
                    end
                    check("drain_offset_zero", line_t'(a[OFFSET_W-1:0]), '0);
                end else begin
                    n_rd++;
                    check("mem_read_addr", line_t'(a), line_t'(cur_addr));
                end
            end else if (pend >= 0) begin
                if (!(mem_read || mem_write)) begin
                    if (!abort_ok) check("mem_req_dropped_early", 1, 0);
                    pend = -1;
                end else begin
                    check("mem_addr_stable", line_t'(mem_address), line_t'(a));
                    check("mem_kind_stable", line_t'(mem_write), line_t'(kind_wr));
                    if (kind_wr) check("mem_wdata_stable", mem_wdata, d);
                end
            end
            if (pend == 0) begin
                mem_resp   = 1'b1;
                mresp_time = $time;
                if (kind_wr) begin
                    backing[a[ADDR_W-1:OFFSET_W]] = d;
                    if (q_tag.size() != 0) begin
                        void'(q_tag.pop_front());
                        void'(q_dat.pop_front());
                    end
                end else begin
                    mem_rdata = mem_val(a[ADDR_W-1:OFFSET_W]);
                end
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
        end
    end

    // Called at a negedge; returns at a negedge with both request lines low.
    task automatic do_req(input bit wr, input logic [ADDR_W-1:0] addr, input line_t data, input bit chk_lat);
        tag_t t;
        int   rd0, lat, idx;
        bit   got, in_q;
        t   = addr[ADDR_W-1:OFFSET_W];
        rd0 = n_rd;
        lat = 1;
        got = 1'b0;
        cur_addr      = addr;
        cache_address = addr;
        cache_wdata   = data;
        cache_write   = wr;
        cache_read    = !wr;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            lat++;
            if (cache_resp) begin
                got = 1'b1;
                break;
            end
        end
        check("cache_resp_timeout", line_t'(got), 1);
        if (got) begin
            if (wr) begin
                idx = find_q(t);
                if (idx >= 0) q_dat[idx] = data;
                else begin
                    q_tag.push_back(t);
                    q_dat.push_back(data);
                end
                golden[t] = data;
                check("write_no_mem_read", line_t'(n_rd - rd0), 0);
                check("buffer_overfill", line_t'(q_tag.size() <= DEPTH), 1);
            end else begin
                in_q = (find_q(t) >= 0);
                check("read_data", cache_rdata, gold(t));
                check("read_mem_access", line_t'(n_rd - rd0), in_q ? 0 : 1);
                if (!in_q) check("miss_resp_latency", line_t'($time - mresp_time), line_t'(T));
            end
            if (chk_lat) check("fast_resp_latency", line_t'(lat), 2);
            @(negedge clk);
            check("resp_single_pulse", line_t'(cache_resp), 0);
        end
        cache_write = 1'b0;
        cache_read  = 1'b0;
    endtask

    task automatic quiesce();
        int i;
        i = 0;
        while ((q_tag.size() != 0 || mem_write || mem_read || mem_resp) && i < 400) begin
            @(negedge clk);
            i++;
        end
        check("quiesce_timeout", line_t'(i < 400), 1);
        i = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_write || mem_read) i++;
        end
        check("idle_after_empty", line_t'(i), 0);
    endtask

    task automatic chk_ev(input string name, input int k, input bit wr, input logic [ADDR_W-1:0] addr, input line_t data);
        if (log_q.size() <= k) check({name, "_missing"}, line_t'(log_q.size()), line_t'(k + 1));
        else begin
            check({name, "_kind"}, line_t'(log_q[k].is_wr), line_t'(wr));
            check({name, "_addr"}, line_t'(log_q[k].addr), line_t'(addr));
            if (wr) check({name, "_data"}, log_q[k].data, data);
        end
    endtask

    task automatic wait_drain_start();
        int i;
        i = 0;
        while (!mem_write && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("drain_start_timeout", line_t'(mem_write), 1);
        @(negedge clk);
    endtask

    initial begin : stim
        int    lsz, wr0, busy;
        line_t dl [5];
        tag_t  t;
        rst = 1'b1; cache_read = 1'b0; cache_write = 1'b0;
        cache_address = '0; cache_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cache_resp", line_t'(cache_resp), 0);
        check("rst_mem_read", line_t'(mem_read), 0);
        check("rst_mem_write", line_t'(mem_write), 0);
        check("rst_cache_rdata", cache_rdata, 0);
        check("rst_mem_address", line_t'(mem_address), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Evict then read the same line: served from the buffer.
        do_req(1'b1, 32'h0000_1000, {8{32'hAAAA_0001}}, 1'b1);
        do_req(1'b0, 32'h0000_1000, '0, 1'b1);
        quiesce();

        // Read miss issued while an eviction is still buffered goes out first.
        lsz = log_q.size();
        do_req(1'b1, 32'h0000_2000, {8{32'hBBBB_0002}}, 1'b1);
        do_req(1'b0, 32'h0000_3000, '0, 1'b0);
        quiesce();
        chk_ev("order_read_first", lsz, 1'b0, 32'h0000_3000, '0);
        chk_ev("order_drain_after", lsz + 1, 1'b1, 32'h0000_2000, {8{32'hBBBB_0002}});

        // Fill, overflow, FIFO drain order across pointer wrap.
        for (int i = 0; i < 5; i++) dl[i] = {8{32'h5000_0000 + 32'(i)}};
        lsz = log_q.size();
        for (int i = 0; i < 4; i++) do_req(1'b1, 32'(32'h100 * (i + 1)), dl[i], 1'b1);
        wr0 = n_wr;
        do_req(1'b1, 32'h0000_0500, dl[4], 1'b0);
        check("full_drains_one", line_t'(n_wr - wr0), 1);
        quiesce();
        for (int i = 0; i < 5; i++) chk_ev("fifo_order", lsz + i, 1'b1, 32'(32'h100 * (i + 1)), dl[i]);

        // Coalescing two evictions of one line.
        wr0 = n_wr;
        lsz = log_q.size();
        do_req(1'b1, 32'h0000_0600, {8{32'hB0B0_0006}}, 1'b1);
        do_req(1'b1, 32'h0000_0600, {8{32'hC0C0_0006}}, 1'b1);
        quiesce();
        check("coalesce_single_write", line_t'(n_wr - wr0), 1);
        chk_ev("coalesce_data", lsz, 1'b1, 32'h0000_0600, {8{32'hC0C0_0006}});

        // Read hitting the head while its drain is in flight.
        resp_delay = 10;
        lsz = log_q.size();
        do_req(1'b1, 32'h0000_0700, {8{32'hD0D0_0007}}, 1'b1);
        wait_drain_start();
        do_req(1'b0, 32'h0000_0700, '0, 1'b0);
        chk_ev("inflight_drain_first", lsz, 1'b1, 32'h0000_0700, {8{32'hD0D0_0007}});
        chk_ev("inflight_then_read", lsz + 1, 1'b0, 32'h0000_0700, '0);
        resp_delay = -1;
        quiesce();

        // Reset with three lines buffered and a drain on the bus.
        resp_delay = 10;
        lsz = log_q.size();
        do_req(1'b1, 32'h0000_0800, {8{32'hE0E0_0008}}, 1'b1);
        do_req(1'b1, 32'h0000_0900, {8{32'hE0E0_0009}}, 1'b1);
        do_req(1'b1, 32'h0000_0A00, {8{32'hE0E0_000A}}, 1'b1);
        wait_drain_start();
        chk_ev("pre_reset_drain", lsz, 1'b1, 32'h0000_0800, {8{32'hE0E0_0008}});
        abort_ok = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_write", line_t'(mem_write), 0);
        check("midrst_mem_read", line_t'(mem_read), 0);
        check("midrst_cache_resp", line_t'(cache_resp), 0);
        rst = 1'b0;
        while (q_tag.size() != 0) begin
            t = q_tag.pop_front();
            void'(q_dat.pop_front());
            golden[t] = mem_val(t);
        end
        resp_delay = -1;
        busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_write || mem_read) busy++;
        end
        check("midrst_buffer_empty", line_t'(busy), 0);
        abort_ok = 1'b0;
        do_req(1'b0, 32'h0000_0900, '0, 1'b0);

        // Random traffic over a small line pool with random offsets and gaps.
        for (int n = 0; n < 200; n++) begin
            logic [ADDR_W-1:0] ra;
            ra = 32'h0000_4000 + 32'($urandom_range(0, 7)) * 32'h20 + 32'($urandom_range(0, 31));
            do_req(1'($urandom_range(0, 1)), ra, {8{$urandom}}, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        quiesce();
        foreach (golden[k]) check("final_coherent", mem_val(k), golden[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #(T * 60000);
        $display("FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
